seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Parametrised multiplexed 7-segment driver: scans NUM_DIGITS digit anodes and shows the value on N in decimal or hex.
//  A sequential double-dabble converter replaces combinational divide/modulo.
//  Adds leading-zero blanking, per-digit decimal points, overflow indication and anti-ghosting blank cycles.
//  Sits between depth-measurement logic and the board's CT/AN pins.
// PARAMETERS
//  NUM_DIGITS   8      number of digits / anode lines (1..8)
//  IN_W         32     width of N (>= 4)
//  REFRESH_DIV  10000  CLK100MHZ cycles per digit slot; constraint REFRESH_DIV >= IN_W+4
// PORTS
//  CLK100MHZ  in   1           single system clock
//  RST        in   1           asynchronous, active-high reset
//  N          in   IN_W        unsigned value to display
//  MODE       in   1           0 = decimal, 1 = hexadecimal
//  BLANK_LZ   in   1           1 = blank leading zeros
//  DP_MASK    in   NUM_DIGITS  bit i = 1 lights decimal point of digit i (0 = rightmost)
//  CT         out  8           segments [0:7] = {a,b,c,d,e,f,g,dp}, active-low
//  AN         out  NUM_DIGITS  digit anodes, active-low, at most one low
//  BUSY       out  1           conversion in progress
// BEHAVIOUR
//  Reset (async, any cycle):
//   - CT = 8'hFF; AN = all 1; BUSY = 0; scan counter = 0; digit index = 0.
//   - Display buffer = all BLANK; FSM = IDLE. An in-flight conversion is aborted.
//  Scan:
//   - Counter runs 0..REFRESH_DIV-1. On wrap, index = (index+1) mod NUM_DIGITS and a tick pulses.
//   - Tick cycle: AN = all 1 (ghost blank). From the next cycle, AN[index] = 0 and CT = seg(buf[index]).
//   - CT and AN are registered; both update on the same edge.
//  Converter FSM (IDLE -> CAPTURE -> SHIFT -> COMMIT -> IDLE):
//   - Starts on the tick when index wraps to 0, and only if IDLE. Ticks while busy are ignored.
//   - CAPTURE: latch N and MODE; BUSY = 1. Changes to N after this cycle do not affect this frame.
//   - SHIFT, decimal: IN_W cycles of add-3 then shift into a 4*NUM_DIGITS BCD register.
//     A bit shifted out of the top digit sets a sticky overflow flag.
//   - SHIFT, hex: 1 cycle, nibble copy. Overflow = any nonzero bit above 4*NUM_DIGITS.
//   - COMMIT: write every digit of the buffer in one cycle (no torn frames); BUSY = 0.
//   - Latency: capture to buffer = IN_W+2 cycles (decimal) or 3 cycles (hex).
//  Digit codes (buffer entries):
//   - 0..15 are digits; DASH and BLANK are extra codes.
//   - Overflow: all digits = DASH (segment g only, CT = 8'hFD with dp off).
//   - BLANK_LZ = 1: digit i > 0 is BLANK when it and every higher digit are 0. Digit 0 is never blanked, so N = 0 shows "0".
//   - DP_MASK is applied at the output, live and not latched: clear CT[7] when DP_MASK[index] = 1, including on BLANK digits.
//   - Hex glyphs A..F use the standard forms A, b, C, d, E, F.
//  Boundaries:
//   - NUM_DIGITS = 1: index stays 0, and the ghost blank still occurs on every tick.
//   - N = 10^NUM_DIGITS - 1: shown fully, no overflow. N = 10^NUM_DIGITS: overflow.
//   - Mid-frame changes to MODE or BLANK_LZ take effect at the next commit.
// STRUCTURE
//  Package display_pkg:
//   - digit_code_t (5-bit enum: D0..D15, DASH, BLANK)
//   - SEG_* constants and function seg(digit_code_t) -> logic[7:0]
//  Sub-module bin2bcd_seq:
//   - Ports: start, value[IN_W], busy, done, bcd[4*NUM_DIGITS], ovf.
//   - Iterative double-dabble. The top level handles hex, blanking and the scan.
// TESTING (bench REFRESH_DIV = 50)
//  1. Reset released, N = 0, BLANK_LZ = 1 -> after the first commit, digit 0 CT = 8'b00000011, digits 1..7 CT = 8'hFF.
//  2. N = 1234, MODE = 0, BLANK_LZ = 0 -> digits 0..3 = 4,3,2,1 (4: 8'b10011001); digits 4..7 = "0"; BUSY high 34 cycles.
//  3. N = 100000000, NUM_DIGITS = 8 -> all digits CT = 8'hFD; N = 99999999 -> all digits "9" (8'b00001001).
//  4. MODE = 1, N = 32'hDEAD_BEEF -> digits 0..7 = F,E,E,b,D,A,E,d; DP_MASK = 8'h04 -> digit 2 CT[7] = 0.
//  5. Scan check -> every tick has exactly 1 cycle with AN = all 1, then exactly one AN low, in order 0..7; N changed during SHIFT -> old value committed.
//  6. RST asserted mid-SHIFT -> CT = 8'hFF and AN = all 1 in the same cycle; after release, the next frame shows the new N correctly.

Source files
------------

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared display types: digit codes, converter states and the 7-segment glyph table.
// Glyph bytes are written {a,b,c,d,e,f,g,dp} from MSB to LSB, active-low.
package display_pkg;

  typedef enum logic [4:0] {
    D0 = 5'd0, D1, D2, D3, D4, D5, D6, D7,
    D8, D9, D10, D11, D12, D13, D14, D15,
    DASH, BLANK
  } digit_code_t;

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_SHIFT, ST_COMMIT} cvt_state_t;

  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  // Entry 15 (F) leftmost, entry 0 rightmost.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

  function automatic logic [7:0] seg(input digit_code_t c);
    logic [4:0] v;
    v = c;
    if (!v[4])       return SEG_HEX[v[3:0]];
    else if (c == DASH) return SEG_DASH;
    else             return SEG_BLANK;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Value/config inputs and display pins of the scan controller, grouped for the top-level port.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8,
  parameter int IN_W       = 32
);
  logic [IN_W-1:0]       N;
  logic                  MODE;
  logic                  BLANK_LZ;
  logic [NUM_DIGITS-1:0] DP_MASK;
  logic [0:7]            CT;
  logic [NUM_DIGITS-1:0] AN;
  logic                  BUSY;

  modport master (output N, MODE, BLANK_LZ, DP_MASK, input CT, AN, BUSY);
  modport slave  (input N, MODE, BLANK_LZ, DP_MASK, output CT, AN, BUSY);
endinterface

// File: rtl/seven_seg_scan_ctrl_bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per cycle, IN_W steps per conversion.
module bin2bcd_seq #(
  parameter int IN_W       = 32,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [IN_W-1:0]         value,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);
  localparam int BCD_W = 4*NUM_DIGITS;
  localparam int CNT_W = $clog2(IN_W+1);

  logic [IN_W-1:0]  r_sh;
  logic [BCD_W-1:0] r_bcd, w_adj;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy, r_ovf;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh   <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (start && !r_busy) begin
      r_sh   <= value;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
      r_cnt  <= CNT_W'(IN_W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      // Whatever leaves the top digit means the value needs more digits than we have.
      r_bcd <= {w_adj[BCD_W-2:0], r_sh[IN_W-1]};
      r_ovf <= r_ovf | w_adj[BCD_W-1];
      r_sh  <= {r_sh[IN_W-2:0], 1'b0};
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

  // done marks the final step; bcd/ovf hold the result from the following cycle.
  assign busy = r_busy;
  assign done = r_busy && (r_cnt == CNT_W'(1));
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-segment driver: digit scan with ghost blanking, per-frame decimal/hex
// conversion committed atomically, leading-zero blanking, live decimal points.
module seven_seg_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int IN_W        = 32,
  parameter int REFRESH_DIV = 10000
) (
  input logic                  CLK100MHZ,
  input logic                  RST,
  seven_seg_scan_ctrl_if.slave bus
);
  localparam int BCD_W = 4*NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV-1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS-1);

  cvt_state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [IN_W-1:0]       r_val;
  logic                  r_mode;
  digit_code_t           r_buf  [NUM_DIGITS];
  digit_code_t           w_code [NUM_DIGITS];
  logic [0:7]            r_ct, w_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  w_wrap, w_frame, w_start;
  logic                  w_cvt_busy, w_cvt_done, w_bcd_ovf, w_hex_ovf, w_ovf;
  logic [BCD_W-1:0]      w_bcd, w_hex, w_nib;

  assign w_wrap    = (r_cnt == CNT_LAST);
  assign w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
  assign w_frame   = w_wrap && (w_idx_nxt == '0);
  assign w_start   = (r_state == ST_CAPTURE) && !bus.MODE && !w_cvt_busy;

  bin2bcd_seq #(.IN_W(IN_W), .NUM_DIGITS(NUM_DIGITS)) u_bcd (
    .clk(CLK100MHZ), .rst(RST), .start(w_start), .value(bus.N),
    .busy(w_cvt_busy), .done(w_cvt_done), .bcd(w_bcd), .ovf(w_bcd_ovf)
  );

  if (IN_W >= BCD_W) begin : g_hex_wide
    assign w_hex = r_val[BCD_W-1:0];
    if (IN_W > BCD_W) begin : g_ovf
      assign w_hex_ovf = |r_val[IN_W-1:BCD_W];
    end else begin : g_no_ovf
      assign w_hex_ovf = 1'b0;
    end
  end else begin : g_hex_narrow
    assign w_hex     = {{(BCD_W-IN_W){1'b0}}, r_val};
    assign w_hex_ovf = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_frame) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_SHIFT;
      ST_SHIFT:   if (r_mode || w_cvt_done) w_state_nxt = ST_COMMIT;
      ST_COMMIT:  w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame contents as they will be committed; blanking walks down from the top digit.
  always_comb begin
    logic lead;
    w_nib = r_mode ? w_hex : w_bcd;
    w_ovf = r_mode ? w_hex_ovf : w_bcd_ovf;
    lead  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) w_code[i] = BLANK;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      lead      = lead && (w_nib[4*i +: 4] == 4'd0);
      w_code[i] = digit_code_t'({1'b0, w_nib[4*i +: 4]});
      if (w_ovf)                                 w_code[i] = DASH;
      else if (bus.BLANK_LZ && lead && (i != 0)) w_code[i] = BLANK;
    end
  end

  always_comb begin
    w_seg = seg(r_buf[r_idx]);
    if (bus.DP_MASK[r_idx]) w_seg[7] = 1'b0;
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_val   <= '0;
      r_mode  <= 1'b0;
      r_ct    <= 8'hFF;
      r_an    <= '1;
      for (int i = 0; i < NUM_DIGITS; i++) r_buf[i] <= BLANK;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      if (w_wrap) r_idx <= w_idx_nxt;
      if (r_state == ST_CAPTURE) begin
        r_val  <= bus.N;
        r_mode <= bus.MODE;
      end
      if (r_state == ST_COMMIT)
        for (int i = 0; i < NUM_DIGITS; i++) r_buf[i] <= w_code[i];
      // One dark cycle after every slot change kills ghosting on the next digit.
      if (w_wrap) begin
        r_ct <= 8'hFF;
        r_an <= '1;
      end else begin
        r_ct <= w_seg;
        r_an <= ~(NUM_DIGITS'(1) << r_idx);
      end
    end
  end

  assign bus.CT   = r_ct;
  assign bus.AN   = r_an;
  assign bus.BUSY = (r_state != ST_IDLE);
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench: table of {N, MODE, BLANK_LZ, DP_MASK, expected CT per digit} plus scan/reset sequences.
module tb_seven_seg_scan_ctrl;
  localparam int ND = 8;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND), .IN_W(IW)) bus ();
  seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .IN_W(IW), .REFRESH_DIV(50)) dut (
    .CLK100MHZ(clk), .RST(rst), .bus(bus)
  );

  typedef struct packed {
    logic [31:0]     n;
    logic            mode;
    logic            blz;
    logic [7:0]      dp;
    logic [7:0][7:0] ct;   // ct[i] = expected CT of digit i
  } vec_t;

  vec_t            vecs [12];
  logic [7:0][7:0] got;
  int              checks = 0;
  int              errors = 0;

  function automatic vec_t mk(logic [31:0] n, logic m, logic b, logic [7:0] d, logic [63:0] c);
    vec_t v;
    v.n = n; v.mode = m; v.blz = b; v.dp = d; v.ct = c;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (bus.BUSY === 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (bus.BUSY === 1'b1) check({nm, "_idle_timeout"}, 1, 0);
  endtask

  // Wait for the next conversion, measure BUSY, then record the first CT seen for each digit.
  task automatic capture_frame(input int exp_busy, input string nm, input int poke_at, input logic [31:0] poke_n);
    int t, blen;
    logic [7:0] seen;
    got = '1;
    t = 0;
    while (bus.BUSY !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    if (bus.BUSY !== 1'b1) begin
      check({nm, "_busy_rise_timeout"}, 0, 1);
      return;
    end
    blen = 0;
    while (bus.BUSY === 1'b1 && blen < 2000) begin
      if (blen == poke_at) bus.N = poke_n;
      @(negedge clk);
      blen++;
    end
    check({nm, "_busy_len"}, blen, exp_busy);
    repeat (2) @(negedge clk);
    seen = '0;
    t = 0;
    while (seen != 8'hFF && t < 1000) begin
      for (int i = 0; i < ND; i++)
        if (bus.AN == ~(8'd1 << i) && !seen[i]) begin
          got[i]  = bus.CT;
          seen[i] = 1'b1;
        end
      @(negedge clk);
      t++;
    end
    check({nm, "_digits_seen"}, seen, 8'hFF);
  endtask

  task automatic cmp_digits(input string nm, input logic [63:0] exp);
    logic [7:0][7:0] e;
    e = exp;
    for (int i = 0; i < ND; i++) check($sformatf("%s_d%0d", nm, i), got[i], e[i]);
  endtask

  task automatic scan_check();
    int prev_idx = -1, cur = -1, blank_run = 0, dig_run = 0, runs = 0;
    int bad_ghost = 0, bad_order = 0, bad_hot = 0, bad_len = 0;
    logic full = 1'b0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      if (bus.AN == 8'hFF) begin
        if (dig_run > 0 && full && dig_run != 49) bad_len++;
        dig_run = 0;
        blank_run++;
      end else begin
        cur = -1;
        for (int i = 0; i < ND; i++) if (bus.AN == ~(8'd1 << i)) cur = i;
        if (cur < 0) bad_hot++;
        else if (dig_run == 0) begin
          full = (prev_idx >= 0);
          if (prev_idx >= 0) begin
            if (blank_run != 1) bad_ghost++;
            if (cur != (prev_idx + 1) % ND) bad_order++;
            runs++;
          end
          blank_run = 0;
          prev_idx  = cur;
        end else if (cur != prev_idx) bad_hot++;
        dig_run++;
      end
    end
    check("scan_ghost_len", bad_ghost, 0);
    check("scan_order", bad_order, 0);
    check("scan_onehot", bad_hot, 0);
    check("scan_slot_len", bad_len, 0);
    check("scan_slots_seen", (runs >= 16), 1);
  endtask

  initial begin
    vecs[0]  = mk(32'd0,          1'b0, 1'b1, 8'h00, 64'hFFFFFFFF_FFFFFF03);
    vecs[1]  = mk(32'd1234,       1'b0, 1'b0, 8'h00, 64'h03030303_9F250D99);
    vecs[2]  = mk(32'd100000000,  1'b0, 1'b0, 8'h00, 64'hFDFDFDFD_FDFDFDFD);
    vecs[3]  = mk(32'd99999999,   1'b0, 1'b0, 8'h00, 64'h09090909_09090909);
    vecs[4]  = mk(32'hDEADBEEF,   1'b1, 1'b0, 8'h04, 64'h85611185_C1606171);
    vecs[5]  = mk(32'd1234,       1'b0, 1'b1, 8'h81, 64'hFEFFFFFF_9F250D98);
    vecs[6]  = mk(32'h000000A0,   1'b1, 1'b1, 8'h00, 64'hFFFFFFFF_FFFF1103);
    vecs[7]  = mk(32'd10000000,   1'b0, 1'b1, 8'h00, 64'h9F030303_03030303);
    vecs[8]  = mk(32'h01234567,   1'b1, 1'b0, 8'h00, 64'h039F250D_9949411F);
    vecs[9]  = mk(32'h89ABCDEF,   1'b1, 1'b1, 8'h00, 64'h010911C1_63856171);
    vecs[10] = mk(32'h01234567,   1'b1, 1'b1, 8'h00, 64'hFF9F250D_9949411F);
    vecs[11] = mk(32'd0,          1'b0, 1'b0, 8'h00, 64'h03030303_03030303);

    rst = 1'b1;
    bus.N = '0; bus.MODE = 1'b0; bus.BLANK_LZ = 1'b1; bus.DP_MASK = '0;
    repeat (3) @(negedge clk);
    check("rst_ct", bus.CT, 8'hFF);
    check("rst_an", bus.AN, 8'hFF);
    check("rst_busy", bus.BUSY, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_an", bus.AN, 8'hFE);
    check("post_rst_ct_blank", bus.CT, 8'hFF);

    for (int k = 0; k < 12; k++) begin
      wait_idle($sformatf("v%0d", k));
      bus.N = vecs[k].n; bus.MODE = vecs[k].mode;
      bus.BLANK_LZ = vecs[k].blz; bus.DP_MASK = vecs[k].dp;
      capture_frame(vecs[k].mode ? 3 : 34, $sformatf("v%0d", k), -1, '0);
      cmp_digits($sformatf("v%0d", k), vecs[k].ct);
    end

    // N changed while shifting: the captured value is the one committed.
    wait_idle("midshift");
    bus.N = 32'd87654321; bus.MODE = 1'b0; bus.BLANK_LZ = 1'b0; bus.DP_MASK = '0;
    capture_frame(34, "midshift", 5, 32'd0);
    cmp_digits("midshift", 64'h011F4149_990D259F);
    capture_frame(34, "midshift_next", -1, '0);
    cmp_digits("midshift_next", 64'h03030303_03030303);

    scan_check();

    // Reset in the middle of a decimal conversion.
    wait_idle("rst_mid");
    bus.N = 32'd99999999;
    begin
      int t = 0;
      while (bus.BUSY !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
      check("rst_mid_busy_seen", bus.BUSY, 1'b1);
    end
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ct", bus.CT, 8'hFF);
    check("rst_mid_an", bus.AN, 8'hFF);
    check("rst_mid_busy", bus.BUSY, 1'b0);
    @(negedge clk);
    bus.N = 32'd4321; bus.BLANK_LZ = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_buf_blank", bus.CT, 8'hFF);
    check("rst_mid_an_d0", bus.AN, 8'hFE);
    capture_frame(34, "rst_mid_frame", -1, '0);
    cmp_digits("rst_mid_frame", 64'hFFFFFFFF_990D259F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
